isdu_seq: RTL and testbench

//   Parametrised LC-3 control sequencer for the SLC-3 datapath. Replaces the fixed two-cycle fetch/store
//   FSM with a MEM_WAIT-cycle memory handshake. Adds BR, JMP, JSR, LDR, STR, PAUSE and ADD/AND/NOT, plus a

---
 rtl/isdu_seq_if.sv | 52 +++++
 rtl/isdu_seq.sv | 187 ++++++++++++++++++
 tb/tb_isdu_seq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/isdu_seq_if.sv
// Shared LC-3 sequencer types and the sequencer <-> SLC-3 datapath control interface.
// The sequencer is the master: it reads IR fields/BEN and drives every load, gate, mux and memory strobe.
package isdu_pkg;
  typedef enum logic [1:0] {
    alu_add  = 2'b00,
    alu_and  = 2'b01,
    alu_not  = 2'b10,
    alu_pass = 2'b11
  } lc3b_aluop;

  localparam logic [3:0] op_br    = 4'b0000;
  localparam logic [3:0] op_add   = 4'b0001;
  localparam logic [3:0] op_jsr   = 4'b0100;
  localparam logic [3:0] op_and   = 4'b0101;
  localparam logic [3:0] op_ldr   = 4'b0110;
  localparam logic [3:0] op_str   = 4'b0111;
  localparam logic [3:0] op_not   = 4'b1001;
  localparam logic [3:0] op_jmp   = 4'b1100;
  localparam logic [3:0] op_pause = 4'b1101;
endpackage

interface isdu_seq_if;
  import isdu_pkg::*;

  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, DRMUX, SR1MUX, ADDR2MUX;
  logic       SR2MUX, ADDR1MUX;
  lc3b_aluop  ALUK;
  logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  modport master (
    input  Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );

  modport slave (
    output Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/isdu_seq.sv
// LC-3 control sequencer for the SLC-3 datapath with a MEM_WAIT-cycle memory handshake,
// retired-instruction counter and illegal-opcode pulse. Outputs decode from state only.
module isdu_seq
  import isdu_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ContinueIR,
  isdu_seq_if.master       bus,
  output logic             Busy,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InsnCount
);

  typedef enum logic [4:0] {
    S_HALTED, S_FETCH, S_FETCH_RD, S_FETCH_IR, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BRT, S_JMP, S_JSR, S_JSR_PC,
    S_LDR_A, S_LDR_RD, S_LDR_WB, S_STR_A, S_STR_D, S_STR_WR,
    S_PAUSE1, S_PAUSE2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wcnt_last;

  assign wcnt_last = (wcnt_q == 4'(MEM_WAIT - 1));
  assign Busy      = (state_q != S_HALTED);
  assign InsnCount = cnt_q;

  assign bus.Mem_CE = 1'b0;
  assign bus.Mem_UB = 1'b0;
  assign bus.Mem_LB = 1'b0;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_HALTED;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every state leaving Decode retires exactly one instruction, illegal ones included.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_DECODE) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d        = state_q;
    wcnt_d         = '0;
    IllegalOp      = 1'b0;
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.PCMUX      = 2'b00;
    bus.DRMUX      = 2'b00;
    bus.SR1MUX     = 2'b00;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.ADDR2MUX   = 2'b00;
    bus.ALUK       = alu_add;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;

    unique case (state_q)
      S_HALTED: if (Run) state_d = S_FETCH;
      S_FETCH: begin
        bus.GatePC = 1'b1;
        bus.LD_MAR = 1'b1;
        bus.LD_PC  = 1'b1;
        state_d    = S_FETCH_RD;
      end
      // wcnt is zero on entry to every access state; MDR captures on the final wait cycle.
      S_FETCH_RD, S_LDR_RD: begin
        bus.Mem_OE = 1'b0;
        bus.LD_MDR = wcnt_last;
        if (wcnt_last) state_d = (state_q == S_FETCH_RD) ? S_FETCH_IR : S_LDR_WB;
        else           wcnt_d  = wcnt_q + 4'd1;
      end
      S_FETCH_IR: begin
        bus.GateMDR = 1'b1;
        bus.LD_IR   = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        bus.LD_BEN = 1'b1;
        case (bus.Opcode)
          op_add:   state_d = S_ADD;
          op_and:   state_d = S_AND;
          op_not:   state_d = S_NOT;
          op_br:    state_d = S_BR;
          op_jmp:   state_d = S_JMP;
          op_jsr:   state_d = S_JSR;
          op_ldr:   state_d = S_LDR_A;
          op_str:   state_d = S_STR_A;
          op_pause: state_d = S_PAUSE1;
          default: begin
            IllegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        bus.SR2MUX  = (state_q == S_NOT) ? 1'b0 : bus.IR_5;
        bus.ALUK    = (state_q == S_ADD) ? alu_add : (state_q == S_AND) ? alu_and : alu_not;
        bus.GateALU = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BR: state_d = bus.BEN ? S_BRT : S_FETCH;
      S_BRT: begin
        bus.ADDR2MUX = 2'b10;
        bus.PCMUX    = 2'b01;
        bus.LD_PC    = 1'b1;
        state_d      = S_FETCH;
      end
      S_JMP: begin
        bus.ADDR1MUX = 1'b1;
        bus.PCMUX    = 2'b01;
        bus.LD_PC    = 1'b1;
        state_d      = S_FETCH;
      end
      S_JSR: begin
        bus.GatePC = 1'b1;
        bus.DRMUX  = 2'b01;
        bus.LD_REG = 1'b1;
        state_d    = S_JSR_PC;
      end
      // JSR targets PC+off11, JSRR targets BaseR + 0.
      S_JSR_PC: begin
        bus.PCMUX    = 2'b01;
        bus.LD_PC    = 1'b1;
        bus.ADDR1MUX = ~bus.IR_11;
        bus.ADDR2MUX = bus.IR_11 ? 2'b11 : 2'b00;
        state_d      = S_FETCH;
      end
      S_LDR_A, S_STR_A: begin
        bus.ADDR1MUX   = 1'b1;
        bus.ADDR2MUX   = 2'b01;
        bus.GateMARMUX = 1'b1;
        bus.LD_MAR     = 1'b1;
        state_d        = (state_q == S_LDR_A) ? S_LDR_RD : S_STR_D;
      end
      S_LDR_WB: begin
        bus.GateMDR = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        state_d     = S_FETCH;
      end
      S_STR_D: begin
        bus.SR1MUX  = 2'b01;
        bus.ALUK    = alu_pass;
        bus.GateALU = 1'b1;
        bus.LD_MDR  = 1'b1;
        state_d     = S_STR_WR;
      end
      S_STR_WR: begin
        bus.Mem_WE = 1'b0;
        if (wcnt_last) state_d = S_FETCH;
        else           wcnt_d  = wcnt_q + 4'd1;
      end
      // Press then release of ContinueIR resumes exactly once.
      S_PAUSE1: if (ContinueIR)  state_d = S_PAUSE2;
      S_PAUSE2: if (!ContinueIR) state_d = S_FETCH;
      default:  state_d = S_HALTED;
    endcase
  end

endmodule

// File: tb/tb_isdu_seq.sv
// Directed bench for isdu_seq: a cycle-by-cycle control trace at MEM_WAIT=2 plus
// handshake-length, store and counter-wrap sequences on differently parametrised instances.
`define ISDU_PACK(i, b, il) {i.LD_MAR, i.LD_MDR, i.LD_IR, i.LD_BEN, i.LD_CC, i.LD_REG, i.LD_PC, i.GatePC, i.GateMDR, i.GateALU, i.GateMARMUX, i.PCMUX, i.DRMUX, i.SR1MUX, i.SR2MUX, i.ADDR1MUX, i.ADDR2MUX, i.ALUK, i.Mem_CE, i.Mem_UB, i.Mem_LB, i.Mem_OE, i.Mem_WE, b, il}

module tb_isdu_seq;
  import isdu_pkg::*;

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, drmux, sr1mux;
    logic       sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic       mem_ce, mem_ub, mem_lb, mem_oe, mem_we, busy, illegal;
  } ctl_t;

  typedef enum {E_HALT, E_FETCH, E_FRD, E_FRDL, E_FIR, E_DEC, E_DECILL, E_ADD, E_AND, E_NOT,
                E_BR, E_BRT, E_JMP, E_JSR, E_JSRPC, E_LDRA, E_LDRWB, E_STRD, E_STRWR, E_PAUSE} exp_e;

  typedef struct {
    logic       rst_n, run, cont;
    logic [3:0] op;
    logic       i5, i11, ben;
    exp_e       e;
    logic [15:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       run_a = 1'b0, run_b = 1'b0, run_c = 1'b0, run_d = 1'b0, cont = 1'b0;
  logic [3:0] op_a = op_add, op_d = op_str;
  logic       ir5_a = 1'b0, ir11_a = 1'b0, ben_a = 1'b0;

  logic        busy_a, busy_b, busy_c, busy_d, ill_a, ill_b, ill_c, ill_d;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic [3:0]  cnt_d;
  ctl_t        ctl_a, ctl_b, ctl_c, ctl_d;

  isdu_seq_if if_a();
  isdu_seq_if if_b();
  isdu_seq_if if_c();
  isdu_seq_if if_d();

  assign if_a.Opcode = op_a;   assign if_a.IR_5 = ir5_a; assign if_a.IR_11 = ir11_a; assign if_a.BEN = ben_a;
  assign if_b.Opcode = op_add; assign if_b.IR_5 = 1'b0;  assign if_b.IR_11 = 1'b0;   assign if_b.BEN = 1'b0;
  assign if_c.Opcode = op_add; assign if_c.IR_5 = 1'b0;  assign if_c.IR_11 = 1'b0;   assign if_c.BEN = 1'b0;
  assign if_d.Opcode = op_d;   assign if_d.IR_5 = 1'b0;  assign if_d.IR_11 = 1'b0;   assign if_d.BEN = 1'b0;

  assign ctl_a = `ISDU_PACK(if_a, busy_a, ill_a);
  assign ctl_b = `ISDU_PACK(if_b, busy_b, ill_b);
  assign ctl_c = `ISDU_PACK(if_c, busy_c, ill_c);
  assign ctl_d = `ISDU_PACK(if_d, busy_d, ill_d);

  isdu_seq #(.MEM_WAIT(2), .CNT_W(16)) dut_a (.Clk(clk), .Reset(rst_n), .Run(run_a), .ContinueIR(cont),
    .bus(if_a), .Busy(busy_a), .IllegalOp(ill_a), .InsnCount(cnt_a));
  isdu_seq #(.MEM_WAIT(1), .CNT_W(16)) dut_b (.Clk(clk), .Reset(rst_n), .Run(run_b), .ContinueIR(1'b0),
    .bus(if_b), .Busy(busy_b), .IllegalOp(ill_b), .InsnCount(cnt_b));
  isdu_seq #(.MEM_WAIT(5), .CNT_W(16)) dut_c (.Clk(clk), .Reset(rst_n), .Run(run_c), .ContinueIR(1'b0),
    .bus(if_c), .Busy(busy_c), .IllegalOp(ill_c), .InsnCount(cnt_c));
  isdu_seq #(.MEM_WAIT(3), .CNT_W(4)) dut_d (.Clk(clk), .Reset(rst_n), .Run(run_d), .ContinueIR(1'b0),
    .bus(if_d), .Busy(busy_d), .IllegalOp(ill_d), .InsnCount(cnt_d));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Expected control word per state, written straight from the state table.
  function automatic ctl_t exp_ctl(input exp_e e, input logic i5, input logic i11);
    ctl_t c;
    c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    c.aluk   = 2'(alu_add);
    c.busy   = (e != E_HALT);
    case (e)
      E_FETCH:  begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      E_FRD:    c.mem_oe = 0;
      E_FRDL:   begin c.mem_oe = 0; c.ld_mdr = 1; end
      E_FIR:    begin c.gate_mdr = 1; c.ld_ir = 1; end
      E_DEC:    c.ld_ben = 1;
      E_DECILL: begin c.ld_ben = 1; c.illegal = 1; end
      E_ADD:    begin c.sr2mux = i5; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      E_AND:    begin c.sr2mux = i5; c.aluk = 2'(alu_and); c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      E_NOT:    begin c.aluk = 2'(alu_not); c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      E_BRT:    begin c.addr2mux = 2'b10; c.pcmux = 2'b01; c.ld_pc = 1; end
      E_JMP:    begin c.addr1mux = 1; c.pcmux = 2'b01; c.ld_pc = 1; end
      E_JSR:    begin c.gate_pc = 1; c.drmux = 2'b01; c.ld_reg = 1; end
      E_JSRPC:  begin c.pcmux = 2'b01; c.ld_pc = 1;
                  if (i11) c.addr2mux = 2'b11; else c.addr1mux = 1; end
      E_LDRA:   begin c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1; end
      E_LDRWB:  begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      E_STRD:   begin c.sr1mux = 2'b01; c.aluk = 2'(alu_pass); c.gate_alu = 1; c.ld_mdr = 1; end
      E_STRWR:  c.mem_we = 0;
      default:  ;
    endcase
    return c;
  endfunction

  vec_t        vecs[$];
  logic        c_run = 1'b0, c_i5 = 1'b0, c_i11 = 1'b0, c_ben = 1'b0;
  logic [3:0]  c_op = op_add;
  logic [15:0] c_cnt = '0;

  task automatic push(input exp_e e, input logic cont_v = 1'b0, input logic rst_v = 1'b1);
    vec_t v;
    v.rst_n = rst_v; v.run = c_run; v.cont = cont_v; v.op = c_op;
    v.i5 = c_i5; v.i11 = c_i11; v.ben = c_ben; v.e = e; v.cnt = c_cnt;
    vecs.push_back(v);
    if (e == E_DEC || e == E_DECILL) c_cnt++;
    if (!rst_v) c_cnt = '0;
  endtask

  task automatic fetch_seq(input logic [3:0] op, input logic i5, input logic i11, input logic ben,
                           input logic ill = 1'b0);
    c_op = op; c_i5 = i5; c_i11 = i11; c_ben = ben;
    push(E_FETCH); push(E_FRD); push(E_FRDL); push(E_FIR); push(ill ? E_DECILL : E_DEC);
  endtask

  function automatic logic is_fetch(input ctl_t c);
    return c.gate_pc & c.ld_mar & c.ld_pc;
  endfunction

  task automatic fetch_timing(input int sel, input int mw);
    ctl_t c;
    int f1 = -1, f2 = -1, oe_low = 0;
    @(negedge clk);
    if (sel == 0) run_b = 1'b1; else run_c = 1'b1;
    for (int cyc = 0; cyc < 40 && f2 < 0; cyc++) begin
      @(negedge clk);
      run_b = 1'b0; run_c = 1'b0;
      c = (sel == 0) ? ctl_b : ctl_c;
      if (is_fetch(c)) begin
        if (f1 < 0) f1 = cyc; else f2 = cyc;
      end
      if (f1 >= 0 && f2 < 0 && !c.mem_oe) oe_low++;
    end
    chk($sformatf("mw%0d_second_fetch_seen", mw), 64'(f2 >= 0), 64'd1);
    chk($sformatf("mw%0d_oe_low_cycles", mw), 64'(oe_low), 64'(mw));
    chk($sformatf("mw%0d_insn_period", mw), 64'(f2 - f1), 64'(mw + 4));
  endtask

  initial begin
    vec_t v;
    ctl_t e, c;
    int   nf, we_low, oe_st, strd, cyc;
    logic after_dec;

    // Main trace on the MEM_WAIT=2 instance.
    c_run = 1'b1; push(E_HALT); c_run = 1'b0;
    fetch_seq(op_add, 1, 0, 0);  push(E_ADD);
    fetch_seq(op_and, 0, 0, 0);  push(E_AND);
    fetch_seq(op_not, 0, 0, 0);  push(E_NOT);
    fetch_seq(op_br, 0, 0, 0);   push(E_BR);
    fetch_seq(op_br, 0, 0, 1);   push(E_BR); push(E_BRT);
    fetch_seq(op_jmp, 0, 0, 0);  push(E_JMP);
    fetch_seq(op_jsr, 0, 1, 0);  push(E_JSR); push(E_JSRPC);
    fetch_seq(op_jsr, 0, 0, 0);  push(E_JSR); push(E_JSRPC);
    fetch_seq(op_ldr, 0, 0, 0);  push(E_LDRA); push(E_FRD); push(E_FRDL); push(E_LDRWB);
    fetch_seq(op_str, 0, 0, 0);  push(E_LDRA); push(E_STRD); push(E_STRWR); push(E_STRWR);
    fetch_seq(op_pause, 0, 0, 0);
    push(E_PAUSE, 0); push(E_PAUSE, 0); push(E_PAUSE, 1); push(E_PAUSE, 1); push(E_PAUSE, 0);
    fetch_seq(4'b1000, 0, 0, 0, 1);
    c_run = 1'b1;
    fetch_seq(op_ldr, 0, 0, 0);
    c_run = 1'b0;
    push(E_LDRA); push(E_FRD, 0, 0); push(E_HALT); push(E_HALT);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      v = vecs[i];
      e = exp_ctl(v.e, ir5_a, ir11_a);
      chk($sformatf("row%0d_%s_ctl", i, v.e.name()), 64'(ctl_a), 64'(e));
      chk($sformatf("row%0d_%s_cnt", i, v.e.name()), 64'(cnt_a), 64'(v.cnt));
      rst_n = v.rst_n; run_a = v.run; cont = v.cont; op_a = v.op;
      ir5_a = v.i5; ir11_a = v.i11; ben_a = v.ben;
    end

    // Handshake length at MEM_WAIT=1 and 5.
    fetch_timing(0, 1);
    fetch_timing(1, 5);

    // Store at MEM_WAIT=3, then counter wrap with CNT_W=4.
    chk("d_idle_busy", 64'(busy_d), 64'd0);
    nf = 0; we_low = 0; oe_st = 0; strd = 0; after_dec = 1'b0; cyc = 0;
    op_d = op_str;
    @(negedge clk);
    run_d = 1'b1;
    while (nf < 2 && cyc < 60) begin
      @(negedge clk);
      run_d = 1'b0;
      cyc++;
      c = ctl_d;
      if (is_fetch(c)) begin
        nf++;
        if (nf == 2) op_d = op_add;
      end
      if (c.ld_ben) after_dec = 1'b1;
      if (after_dec && !c.mem_oe) oe_st++;
      if (!c.mem_we) we_low++;
      if (c.gate_alu && c.ld_mdr) begin
        strd++;
        chk("d_strd_ctl", 64'(c), 64'(exp_ctl(E_STRD, 1'b0, 1'b0)));
      end
    end
    chk("d_store_done", 64'(nf), 64'd2);
    chk("d_strd_cycles", 64'(strd), 64'd1);
    chk("d_we_low_cycles", 64'(we_low), 64'd3);
    chk("d_oe_low_during_store", 64'(oe_st), 64'd0);
    chk("d_cnt_after_store", 64'(cnt_d), 64'd1);

    cyc = 0;
    while (nf < 18 && cyc < 250) begin
      @(negedge clk);
      cyc++;
      if (is_fetch(ctl_d)) nf++;
    end
    chk("d_fetches_reached", 64'(nf), 64'd18);
    chk("d_cnt_wrap_17", 64'(cnt_d), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`undef ISDU_PACK
